// File: rtl/ssd_pkg.sv
// Shared types and constants for the eight-digit seven-segment scanner:
// FSM states, active-low hex segment table, idle drive levels, index stepping.
package ssd_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    SHOW  = 1'b1
  } state_t;

  localparam logic [7:0] CATH_OFF = 8'hFF;
  localparam logic [7:0] AN_OFF   = 8'hFF;

  // Active-low {a,b,c,d,e,f,g}, indexed by the hex value.
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Lowest enabled index above cur, else the lowest enabled overall; cur if none.
  function automatic logic [2:0] next_idx(input logic [7:0] en, input logic [2:0] cur);
    logic [2:0] cand;
    next_idx = cur;
    for (int k = 8; k >= 1; k--) begin
      cand = cur + 3'(k);
      if (en[cand]) next_idx = cand;
    end
  endfunction

endpackage

// File: rtl/ssd_scan_ctrl_if.sv
// Display-side bundle of the scanner: digit data/enables in, anode/cathode drive out.
// The brightness input exists only when SSD_BRIGHTNESS_EN is defined.
interface ssd_scan_ctrl_if;

  logic [31:0] digits_in;
  logic [7:0]  digit_en;
  logic [7:0]  dp_in;
  logic [7:0]  An;
  logic [7:0]  Cath;
  logic [2:0]  scan_idx;
  logic        frame_tick;
`ifdef SSD_BRIGHTNESS_EN
  logic [2:0]  brightness;

  modport master (output digits_in, digit_en, dp_in, brightness,
                  input  An, Cath, scan_idx, frame_tick);
  modport slave  (input  digits_in, digit_en, dp_in, brightness,
                  output An, Cath, scan_idx, frame_tick);
`else
  modport master (output digits_in, digit_en, dp_in,
                  input  An, Cath, scan_idx, frame_tick);
  modport slave  (input  digits_in, digit_en, dp_in,
                  output An, Cath, scan_idx, frame_tick);
`endif

endinterface

// File: rtl/ssd_hex_decode.sv
// Combinational hex nibble to active-low seven-segment pattern {a..g}.
module ssd_hex_decode
  import ssd_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scanner for an eight-digit common-anode display with dead-time
// between slots. Optional SSD_BRIGHTNESS_EN adds a 3-bit per-slot anode duty control.
module ssd_scan_ctrl
  import ssd_pkg::*;
#(
  parameter int SCAN_DIV  = 262143,
  parameter int BLANK_CYC = 1024
) (
  input  logic            Clk,
  input  logic            Reset,
  ssd_scan_ctrl_if.slave  bus
);

  localparam int MAXC = (SCAN_DIV > BLANK_CYC - 1) ? SCAN_DIV : BLANK_CYC - 1;
  localparam int CW   = (MAXC < 1) ? 1 : $clog2(MAXC + 1);
  localparam logic [CW-1:0] SHOW_LAST  = CW'(SCAN_DIV);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYC - 1);

  state_t        state_reg, state_next;
  logic [CW-1:0] cnt_reg, cnt_next;
  logic [2:0]    idx_reg, idx_next;
  logic [7:0]    an_reg, an_next;
  logic [7:0]    cath_reg, cath_next;
  logic          tick_reg, tick_next;
  logic [6:0]    seg_sel;
  logic [7:0]    an_sel;
  logic          an_on;

  ssd_hex_decode u_decode (
    .nibble (bus.digits_in[{idx_next, 2'b00} +: 4]),
    .seg    (seg_sel)
  );

`ifdef SSD_BRIGHTNESS_EN
  localparam logic [CW+3:0] SLOT_LEN = (CW+4)'(SCAN_DIV + 1);
  // Lit while cnt*8 < (brightness+1)*slot_len; evaluated on the count being entered.
  assign an_on = ({1'b0, cnt_next, 3'b000} <
                  SLOT_LEN * {{(CW+1){1'b0}}, bus.brightness} + SLOT_LEN);
`else
  assign an_on = 1'b1;
`endif

  for (genvar gi = 0; gi < 8; gi++) begin : g_an
    assign an_sel[gi] = ~(an_on && (idx_next == 3'(gi)));
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg + CW'(1);
    idx_next   = idx_reg;
    tick_next  = 1'b0;
    case (state_reg)
      BLANK: begin
        if (cnt_reg == BLANK_LAST) begin
          cnt_next = cnt_reg;
          if (bus.digit_en != 8'h00) begin
            state_next = SHOW;
            cnt_next   = '0;
            if (!bus.digit_en[idx_reg]) idx_next = next_idx(bus.digit_en, idx_reg);
          end
        end
      end
      SHOW: begin
        // Losing the current digit's enable cuts the slot short.
        if (!bus.digit_en[idx_reg] || cnt_reg == SHOW_LAST) begin
          state_next = BLANK;
          cnt_next   = '0;
          if (bus.digit_en != 8'h00) begin
            idx_next  = next_idx(bus.digit_en, idx_reg);
            tick_next = (idx_next <= idx_reg);
          end
        end
      end
      default: begin
        state_next = BLANK;
        cnt_next   = '0;
      end
    endcase
  end

  always_comb begin
    an_next   = AN_OFF;
    cath_next = CATH_OFF;
    if (state_next == SHOW) begin
      an_next   = an_sel;
      // Cathodes are captured once on slot entry and held for the whole slot.
      cath_next = (state_reg == SHOW) ? cath_reg
                                      : {seg_sel, ~bus.dp_in[idx_next]};
    end
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_reg <= BLANK;
      cnt_reg   <= '0;
      idx_reg   <= '0;
      an_reg    <= AN_OFF;
      cath_reg  <= CATH_OFF;
      tick_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      idx_reg   <= idx_next;
      an_reg    <= an_next;
      cath_reg  <= cath_next;
      tick_reg  <= tick_next;
    end
  end

  assign bus.An         = an_reg;
  assign bus.Cath       = cath_reg;
  assign bus.scan_idx   = idx_reg;
  assign bus.frame_tick = tick_reg;

endmodule

// File: doc/ssd_scan_ctrl.md
SSD_SCAN_CTRL -- requirements
Module: ssd_scan_ctrl

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 262143, giving a SHOW slot length of SCAN_DIV+1 cycles (~381 Hz per digit at 100 MHz).
REQ-002 SHALL have parameter BLANK_CYC, default 1024, giving an anti-ghost dead-time length in cycles; legal range is at least 1.
REQ-003 SHALL have ports Clk (in, 1): the single clock; Reset (in, 1): synchronous, active-high.
REQ-004 SHALL have port digits_in (in, 32): eight hex nibbles; nibble k = digits_in[4k+3:4k] drives digit k.
REQ-005 SHALL have port digit_en (in, 8): per-digit enable; bit k enables digit k.
REQ-006 SHALL have port dp_in (in, 8): decimal point request; bit k lights the Dp of digit k.
REQ-007 SHALL have port An (out, 8): active-low anodes; An[k] drives digit k.
REQ-008 SHALL have port Cath (out, 8): active-low {Ca,Cb,Cc,Cd,Ce,Cf,Cg,Dp}.
REQ-009 SHALL have port scan_idx (out, 3): index of the digit currently owning the display.
REQ-010 SHALL have port frame_tick (out, 1): single-cycle pulse at the end of each scan frame.

Function
REQ-011 SHALL implement a two-state FSM, BLANK and SHOW, with all outputs registered.
- BLANK: An=8'hFF, Cath=8'hFF; lasts BLANK_CYC cycles.
- SHOW: lasts SCAN_DIV+1 cycles.
REQ-012 On BLANK→SHOW, the block SHALL latch nibble[scan_idx] and dp_in[scan_idx]; the displayed value SHALL stay stable for the whole slot even if inputs change.
REQ-013 In SHOW, the block SHALL drive An[scan_idx]=0 with all other An bits 1, and Cath = decoded nibble, with Dp=0 when the latched dp bit is 1.
REQ-014 Decode (abcdefg) SHALL be: 0→0000001, 1→1001111, 8→0000000, A→0001000, F→0111000; all 16 hex values SHALL be covered.
REQ-015 At the end of a SHOW slot, the block SHALL:
- set scan_idx to the lowest enabled index greater than the current one, wrapping to the lowest enabled index;
- then enter BLANK.
REQ-016 frame_tick SHALL assert for exactly the one cycle of the SHOW→BLANK transition in which scan_idx wraps (new index ≤ old). With a single digit enabled, it asserts every slot.
REQ-017 If digit_en == 0, the block SHALL stay in BLANK with An=8'hFF, Cath=8'hFF, frame_tick=0, and scan_idx held.
REQ-018 BLANK→SHOW with the current index disabled SHALL first advance per REQ-015; the BLANK count SHALL NOT restart.
REQ-019 If digit_en[scan_idx] falls during SHOW, the anode SHALL go high on the next cycle, the FSM SHALL enter BLANK, and the index SHALL advance per REQ-015.
REQ-020 Counters SHALL be wide enough for max(SCAN_DIV, BLANK_CYC-1) and SHALL reset to 0 on every state change.

Reset
REQ-021 While Reset=1 at a Clk edge, the block SHALL set:
- state=BLANK, counter=0, scan_idx=0;
- An=8'hFF, Cath=8'hFF, frame_tick=0.
REQ-022 Reset asserted mid-slot SHALL take effect on the next edge with no completion of the slot; the first SHOW SHALL begin BLANK_CYC cycles after Reset deasserts.

Configuration
REQ-023 With SSD_BRIGHTNESS_EN defined:
- the block SHALL add input brightness (3 bits);
- in SHOW, An[scan_idx]=0 SHALL hold only while counter·8 < (brightness+1)·(SCAN_DIV+1), and An=8'hFF for the rest of the slot;
- slot timing SHALL be unchanged.
REQ-024 Without SSD_BRIGHTNESS_EN, the port SHALL be absent and the anode SHALL be asserted for the full slot.

Structure
REQ-025 Shared package ssd_pkg SHALL hold:
- the FSM state typedef (BLANK, SHOW);
- the 16-entry hex-to-segment constant table;
- localparams CATH_OFF=8'hFF and AN_OFF=8'hFF.
REQ-026 Decode SHALL be a combinational sub-module ssd_hex_decode (nibble in, 7-bit segments out); the FSM, counters and index selection SHALL live in ssd_scan_ctrl.

Verification (SCAN_DIV=3, BLANK_CYC=2)
REQ-027 Reset release, digit_en=8'h01, digits_in nibble0=0, dp_in=8'h01 -> 2 cycles An=FF, then 4 cycles An=FE, Cath=8'b00000010; frame_tick pulses every 6 cycles.
REQ-028 digit_en=8'h85, digits_in=32'hF0000A08 -> slots in order 0 (8), 2 (A), 7 (F), then 0 again; frame_tick only on the 7→0 transition.
REQ-029 digit_en drops 8'h05→8'h01 during digit 2's slot -> An=FF on the next cycle, BLANK 2 cycles, then digit 0.
REQ-030 digits_in changes mid-slot -> Cath is unchanged until the next slot; digit_en=0 -> An=FF, Cath=FF held indefinitely, no frame_tick.
REQ-031 Reset pulsed mid-SHOW -> An=FF, scan_idx=0 on the next edge; SSD_BRIGHTNESS_EN with brightness=3 -> anode low for 2 of 4 slot cycles.
